// File: rtl/snes_ctrl_reader.sv
// snes_ctrl_reader
//
// Polls one SNES-style serial game controller and presents its buttons as a
// parallel word. One `tick` pulse equals one protocol half-period. A poll is
// started by a one-cycle `start` pulse while idle. ctrl_latch is held high for
// LATCH_TICKS ticks, then NUM_BITS bits are sampled on ctrl_clk-high phases,
// separated by NUM_BITS-1 one-tick-wide ctrl_clk low pulses. A completed poll
// loads `buttons` and raises `buttons_valid` for exactly one cycle.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   tick           pacing pulse, each high cycle counts as one tick
//   start          poll request pulse, dropped unless idle
//   ctrl_data      serial data from the controller, active-low (0 = pressed)
//   ctrl_latch     latch strobe to the controller
//   ctrl_clk       serial clock to the controller, idles high
//   buttons        last completed poll, 1 = pressed, bit i = i-th bit shifted in
//   buttons_valid  one-cycle strobe on the cycle `buttons` updates
//   busy           high whenever a poll is in progress
//
// Build option:
//   SNES_CTRL_SYNC_EN  when defined, ctrl_data passes through a two-flop
//                      synchroniser (reset to 1) before sampling. When
//                      undefined, ctrl_data is sampled directly.

module snes_ctrl_reader #(
    parameter int unsigned NUM_BITS    = 16,
    parameter int unsigned LATCH_TICKS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                ctrl_data,
    output logic                ctrl_latch,
    output logic                ctrl_clk,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_valid,
    output logic                busy
);

    localparam int unsigned TickW = $clog2(LATCH_TICKS + 1);
    localparam int unsigned IdxW  = $clog2(NUM_BITS);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StBitHi,
        StBitLo,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic                valid_q, valid_d;
    logic                latch_q;
    logic                clk_q;
    logic                busy_q;
    logic                data_in;

`ifdef SNES_CTRL_SYNC_EN
    // Reset to 1 so an idle (unpressed) line is seen while the chain fills.
    logic [1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ctrl_data};
        end
    end

    assign data_in = sync_q[1];
`else
    assign data_in = ctrl_data;
`endif

    // Ticks are only acted on while the state register already holds a state,
    // so a tick in the cycle that decides a transition is never counted twice.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
        valid_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLatch;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                end
            end
            StLatch: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_d == TickW'(LATCH_TICKS)) begin
                        state_d = StBitHi;
                    end
                end
            end
            StBitHi: begin
                if (tick) begin
                    shift_d[bit_idx_q] = ~data_in;
                    if (bit_idx_q == IdxW'(NUM_BITS - 1)) begin
                        // buttons and the strobe are registered on entry to
                        // StDone so both are visible during that cycle.
                        state_d   = StDone;
                        buttons_d = shift_d;
                        valid_d   = 1'b1;
                    end else begin
                        state_d = StBitLo;
                    end
                end
            end
            StBitLo: begin
                if (tick) begin
                    state_d   = StBitHi;
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            latch_q    <= 1'b0;
            clk_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            // Pin outputs are decoded from the next state so they change
            // together with the state register.
            latch_q    <= (state_d == StLatch);
            clk_q      <= (state_d != StBitLo);
            busy_q     <= (state_d != StIdle);
        end
    end

    assign ctrl_latch    = latch_q;
    assign ctrl_clk      = clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_snes_ctrl_reader.sv
// Self-checking bench for snes_ctrl_reader with a behavioural controller
// model and per-poll protocol monitors.

module tb_snes_ctrl_reader;

    localparam int NB = 16;
    localparam int LT = 2;
    localparam int P  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          ctrl_data = 1'b1;
    logic          ctrl_latch;
    logic          ctrl_clk;
    logic [NB-1:0] buttons;
    logic          buttons_valid;
    logic          busy;

    snes_ctrl_reader #(
        .NUM_BITS   (NB),
        .LATCH_TICKS(LT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .ctrl_data    (ctrl_data),
        .ctrl_latch   (ctrl_latch),
        .ctrl_clk     (ctrl_clk),
        .buttons      (buttons),
        .buttons_valid(buttons_valid),
        .busy         (busy)
    );

    initial forever #5 clock = ~clock;

    // Tick is high in every cycle whose index is a multiple of P.
    int cyc = 0;
    initial forever begin
        @(negedge clock);
        cyc  = cyc + 1;
        tick = (cyc % P == 0);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model and monitor state (written only by the monitor, except
    // the stimulus controls pad_mask / glitch_* / mon_en).
    logic [NB-1:0] pad_mask   = '0;
    int            glitch_en  = 0;
    int            glitch_bit = 0;
    int            mon_en     = 0;

    int            mon_idx      = 0;
    logic          prev_clk     = 1'b1;
    logic          prev_latch   = 1'b0;
    logic          prev_valid   = 1'b0;
    logic [NB-1:0] prev_btn     = '0;
    int            latch_rises  = 0;
    int            latch_cycles = 0;
    int            latch_ticks  = 0;
    int            clk_lows     = 0;
    int            bad_low      = 0;
    int            low_w        = 0;
    int            low_t        = 0;
    int            valid_cnt    = 0;
    int            valid_bad    = 0;
    int            hold_bad     = 0;
    logic [NB-1:0] valid_btn    = '0;

    initial forever begin
        @(negedge clock);
        #2;
        // Controller: latch reloads bit 0, each ctrl_clk rise advances a bit.
        if (ctrl_latch) begin
            mon_idx = 0;
        end else if (!prev_clk && ctrl_clk && mon_idx < NB) begin
            mon_idx = mon_idx + 1;
        end
        if (mon_idx < NB) ctrl_data = ~pad_mask[mon_idx];
        else              ctrl_data = 1'b0;
        // Late press: pin goes low only 1 cycle before the sampling tick.
        if (glitch_en != 0 && mon_idx == glitch_bit && ctrl_clk && !ctrl_latch && busy &&
            (cyc % P == P - 1 || cyc % P == 0)) begin
            ctrl_data = 1'b0;
        end

        if (mon_en != 0 && !reset) begin
            if (ctrl_latch && !prev_latch) latch_rises++;
            if (ctrl_latch) begin
                latch_cycles++;
                if (tick) latch_ticks++;
            end
            if (!ctrl_clk) begin
                low_w++;
                if (tick) low_t++;
            end
            if (!prev_clk && ctrl_clk) begin
                clk_lows++;
                if (low_w != P || low_t != 1) bad_low++;
                low_w = 0;
                low_t = 0;
            end
            if (buttons_valid) begin
                valid_cnt++;
                valid_btn = buttons;
            end
            if (prev_valid && (buttons_valid || busy)) valid_bad++;
            if (buttons != prev_btn && !buttons_valid) hold_bad++;
        end else begin
            low_w = 0;
            low_t = 0;
        end
        prev_clk   = ctrl_clk;
        prev_latch = ctrl_latch;
        prev_valid = buttons_valid;
        prev_btn   = buttons;
    end

    // Called at negedge+1; start is high for exactly one cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int v0, output int seen);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            #3;
            if (valid_cnt > v0) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic run_poll(input logic [NB-1:0] mask, input logic [NB-1:0] exp,
                            input int align, input int gap);
        int v0, r0, lc0, lt0, cl0, bl0, ks, k, n, seen;
        pad_mask = mask;
        repeat (gap) @(negedge clock);
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clock);
            #1;
            if (align == 0 || tick) break;
        end
        v0  = valid_cnt;
        r0  = latch_rises;
        lc0 = latch_cycles;
        lt0 = latch_ticks;
        cl0 = clk_lows;
        bl0 = bad_low;
        ks  = cyc;
        pulse_start();
        wait_valid(v0, seen);
        check_eq("valid_seen", seen, 1);
        check_eq("buttons_at_valid", 32'(valid_btn), 32'(exp));
        @(negedge clock);
        #3;
        check_eq("busy_after_done", 32'(busy), 0);
        check_eq("buttons_hold", 32'(buttons), 32'(exp));
        check_eq("valid_count", valid_cnt - v0, 1);
        check_eq("latch_pulses", latch_rises - r0, 1);
        // Latch spans the cycles after start up to the LT-th later tick.
        k = ks;
        n = 0;
        while (n < LT) begin
            k++;
            if (k % P == 0) n++;
        end
        check_eq("latch_width", latch_cycles - lc0, k - ks);
        check_eq("latch_ticks", latch_ticks - lt0, LT);
        check_eq("clk_low_pulses", clk_lows - cl0, NB - 1);
        check_eq("clk_low_shape", bad_low - bl0, 0);
        if (align != 0) check_eq("latch_width_aligned", latch_cycles - lc0, LT * P);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int v0, r0, seen;
        logic [NB-1:0] m;

        // Reset asserted while ticks run: outputs return at once and hold.
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_latch", 32'(ctrl_latch), 0);
        check_eq("rst_clk", 32'(ctrl_clk), 1);
        check_eq("rst_buttons", 32'(buttons), 0);
        check_eq("rst_valid", 32'(buttons_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        repeat (5) @(negedge clock);
        #1;
        check_eq("rst_hold_clk", 32'(ctrl_clk), 1);
        check_eq("rst_hold_busy", 32'(busy), 0);
        reset  = 1'b0;
        mon_en = 1;

        // Full poll, start coincident with a tick.
        run_poll(16'h0109, 16'h0109, 1, 2);

        // Randomised polls.
        for (int it = 0; it < 8; it++) begin
            m = NB'($urandom());
            run_poll(m, m, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        // Second start during bit 5 is dropped.
        m        = NB'($urandom());
        pad_mask = m;
        v0       = valid_cnt;
        r0       = latch_rises;
        @(negedge clock);
        #1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (mon_idx == 5 && busy) begin
                seen = 1;
                break;
            end
        end
        check_eq("busy_reached_bit5", seen, 1);
        pulse_start();
        wait_valid(v0, seen);
        check_eq("busy_valid_seen", seen, 1);
        repeat (40) @(negedge clock);
        #3;
        check_eq("busy_valid_count", valid_cnt - v0, 1);
        check_eq("busy_latch_pulses", latch_rises - r0, 1);
        check_eq("busy_buttons", 32'(buttons), 32'(m));
        run_poll(16'hA5C3, 16'hA5C3, 0, 3);

        // Start in the DONE cycle is ignored.
        pad_mask = 16'h1234;
        r0       = latch_rises;
        @(negedge clock);
        #1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            #1;
            if (buttons_valid) begin
                seen = 1;
                break;
            end
        end
        check_eq("done_reached", seen, 1);
        pulse_start();
        repeat (20) @(negedge clock);
        #3;
        check_eq("done_start_dropped", latch_rises - r0, 1);
        check_eq("done_start_busy", 32'(busy), 0);

        // Start in the first IDLE cycle is accepted.
        pad_mask = 16'h4321;
        v0       = valid_cnt;
        r0       = latch_rises;
        @(negedge clock);
        #1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            #1;
            if (buttons_valid) begin
                seen = 1;
                break;
            end
        end
        check_eq("idle0_first_done", seen, 1);
        @(negedge clock);
        #1;
        check_eq("idle0_busy_low", 32'(busy), 0);
        pulse_start();
        wait_valid(v0 + 1, seen);
        check_eq("idle0_second_valid", seen, 1);
        check_eq("idle0_latch_pulses", latch_rises - r0, 2);
        check_eq("idle0_buttons", 32'(valid_btn), 32'h4321);

        // Reset during BIT_LO of bit 7.
        run_poll(16'h0FFF, 16'h0FFF, 0, 2);
        v0 = valid_cnt;
        @(negedge clock);
        #1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (mon_idx == 7 && !ctrl_clk && busy) begin
                seen = 1;
                break;
            end
        end
        check_eq("midrst_reached", seen, 1);
        reset = 1'b1;
        #1;
        check_eq("midrst_buttons", 32'(buttons), 0);
        check_eq("midrst_latch", 32'(ctrl_latch), 0);
        check_eq("midrst_clk", 32'(ctrl_clk), 1);
        check_eq("midrst_valid", 32'(buttons_valid), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        #3;
        check_eq("midrst_no_valid", valid_cnt - v0, 0);
        check_eq("midrst_buttons_held", 32'(buttons), 0);
        run_poll(16'h0800, 16'h0800, 0, 1);

        // Late change on bit 4: captured only without the synchroniser.
        glitch_en  = 1;
        glitch_bit = 4;
`ifdef SNES_CTRL_SYNC_EN
        run_poll(16'h0109, 16'h0109, 0, 2);
`else
        run_poll(16'h0109, 16'h0119, 0, 2);
`endif
        glitch_en = 0;
        run_poll(16'h0109, 16'h0109, 1, 2);

        check_eq("valid_single_cycle", valid_bad, 0);
        check_eq("buttons_change_only_on_valid", hold_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
